// File: rtl/regfile_writeback.sv
// Write-back stage: registers the MEM result, drives the r0-suppressed register-file write
// port and counts retired instructions. Define WB_FWD_EN to add the WB->EX forwarding hits.
module regfile_writeback #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic          mem_mem_to_reg,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_load_data,
  input  logic [AW-1:0] mem_write_r,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_write_r,
  output logic          wb_reg_write,
  output logic [31:0]   retire_count
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  output logic          fwd_a,
  output logic          fwd_b
`endif
);

  localparam int unsigned CW = 32;

  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_r_q, write_r_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] retire_q, retire_d;

  // Flush beats stall; the load/ALU mux sits ahead of the register.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    write_r_d   = write_r_q;
    data_d      = data_q;
    retire_d    = retire_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      write_r_d   = '0;
      data_d      = '0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      write_r_d   = mem_write_r;
      data_d      = mem_mem_to_reg ? mem_load_data : mem_alu_result;
      if (mem_valid) begin
        retire_d = retire_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      write_r_q   <= '0;
      data_q      <= '0;
      retire_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      write_r_q   <= write_r_d;
      data_q      <= data_d;
      retire_q    <= retire_d;
    end
  end

  assign wb_data      = data_q;
  assign wb_write_r   = write_r_q;
  assign wb_reg_write = valid_q & reg_write_q & (write_r_q != '0);
  assign retire_count = retire_q;

`ifdef WB_FWD_EN
  // Bypass hit when the pending write targets an EX source; value is wb_data.
  assign fwd_a = wb_reg_write & (write_r_q == ex_rs);
  assign fwd_b = wb_reg_write & (write_r_q == ex_rt);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a spec-level model pushes expected WB state per
// cycle, a monitor pops and compares after each posedge. Honours WB_FWD_EN.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [4:0]  mem_write_r;
  logic [31:0] wb_data;
  logic [4:0]  wb_write_r;
  logic        wb_reg_write;
  logic [31:0] retire_count;
`ifdef WB_FWD_EN
  logic [4:0]  ex_rs, ex_rt;
  logic        fwd_a, fwd_b;
`endif

  regfile_writeback #(.DW(32), .AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_write_r    (mem_write_r),
    .wb_data        (wb_data),
    .wb_write_r     (wb_write_r),
    .wb_reg_write   (wb_reg_write),
    .retire_count   (retire_count)
`ifdef WB_FWD_EN
    ,
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wr;
    logic        we;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] rf[32];

  // Reference model state: what the WB stage should hold.
  logic        m_valid, m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_data, m_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model commits at the negedge.
  always @(negedge clk) begin
    if (rst_n && wb_reg_write) rf[wb_write_r] <= wb_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_wr = '0; m_data = '0; m_cnt = '0;
  endtask

  // One cycle of stimulus: drive at negedge, model the following posedge, push expectation.
  task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                      input logic m2r, input logic [31:0] alu, input logic [31:0] ld,
                      input logic [4:0] wr);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; mem_valid = v; mem_reg_write = rw;
    mem_mem_to_reg = m2r; mem_alu_result = alu; mem_load_data = ld; mem_write_r = wr;
    if (fl) begin
      m_valid = 1'b0; m_rw = 1'b0; m_wr = '0; m_data = '0;
    end else if (!st) begin
      m_valid = v; m_rw = rw; m_wr = wr;
      m_data  = m2r ? ld : alu;
      if (v) m_cnt = m_cnt + 32'd1;
    end
    e.data = m_data;
    e.wr   = m_wr;
    e.we   = m_valid && m_rw && (m_wr != 5'd0);
    e.cnt  = m_cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: compare one expectation per posedge once any are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_write_r", 32'(wb_write_r), 32'(e.wr));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.we));
        chk("retire_count", retire_count, e.cnt);
`ifdef WB_FWD_EN
        chk("fwd_a", 32'(fwd_a), 32'(e.we && (e.wr == ex_rs)));
        chk("fwd_b", 32'(fwd_b), 32'(e.we && (e.wr == ex_rt)));
`endif
      end
    end
  end

  initial begin
    logic [31:0] saved;
    int          budget;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    // Reset with every input active.
    rst_n = 1'b0;
    stall = 1'b1; flush = 1'b1; mem_valid = 1'b1; mem_reg_write = 1'b1; mem_mem_to_reg = 1'b1;
    mem_alu_result = '1; mem_load_data = '1; mem_write_r = '1;
`ifdef WB_FWD_EN
    ex_rs = 5'd0; ex_rt = 5'd0;
`endif
    model_reset();
    #7;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_write_r", 32'(wb_write_r), 32'h0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'h0);
    chk("rst_retire_count", retire_count, 32'h0);
`ifdef WB_FWD_EN
    chk("rst_fwd_a", 32'(fwd_a), 32'h0);
    chk("rst_fwd_b", 32'(fwd_b), 32'h0);
`endif

    // ALU write to r9, released with the first stimulus.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00AB, 32'h0, 5'd9);
    rst_n = 1'b1;
    // Load path to r18.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd18);
    #1 chk("rf_r9_read", rf[9], 32'h0000_00AB);
    // r0 write suppressed but still retired.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd0);
    // Write to r11 for stall and forwarding checks.
`ifdef WB_FWD_EN
    ex_rs = 5'd11; ex_rt = 5'd19;
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd11);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom_range(1, 31)));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 5'd7);
    // r0 destination with ex_rs=0 must not raise a forward.
`ifdef WB_FWD_EN
    ex_rs = 5'd0;
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 5'd0);

    // Counter wrap: preload one below the wrap point.
    @(posedge clk);
    #2;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 5'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h78, 32'h0, 5'd4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom, $urandom,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
`ifdef WB_FWD_EN
      ex_rs = 5'($urandom); ex_rt = 5'($urandom);
`endif
    end

    // Asynchronous reset before the negedge discards a pending write.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0005, 32'h0, 5'd5);
    @(posedge clk);
    #2;
    saved = rf[5];
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_data", wb_data, 32'h0);
    chk("midrst_wb_write_r", 32'(wb_write_r), 32'h0);
    chk("midrst_wb_reg_write", 32'(wb_reg_write), 32'h0);
    chk("midrst_retire_count", retire_count, 32'h0);
    @(negedge clk);
    #1;
    chk("midrst_rf_r5", rf[5], saved);
    model_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1357_9BDF, 5'd21);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
